// File: rtl/aes_spi_master.sv
// aes_spi_master: initiator for the serial AES link. Streams message then key
// LSB-first on SIMO under CSS, then collects the 128-bit result from SOMI.
module aes_spi_master #(
   parameter int unsigned MSG_W   = 128,
   parameter int unsigned KEY_MAX = 256,
   parameter int unsigned CNT_W   = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode_in,
   input  logic [1:0]         size_in,
   input  logic [MSG_W-1:0]   msg_in,
   input  logic [KEY_MAX-1:0] key_in,
   output logic               SIMO,
   output logic               CSS,
   output logic               mode,
   output logic [1:0]         size,
   input  logic               SOMI,
   output logic [MSG_W-1:0]   result,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {S_IDLE, S_WMSG, S_GAP, S_WKEY, S_RD, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   kb_last;
   logic [MSG_W-1:0]   msg_q, msg_d;
   logic [KEY_MAX-1:0] key_q, key_d;
   logic [MSG_W-1:0]   shadow_q, shadow_d;
   logic [MSG_W-1:0]   result_q, result_d;
   logic               mode_lat_q, mode_lat_d;
   logic [1:0]         size_q, size_d;
   logic               simo_q, simo_d;
   logic               css_q, css_d;
   logic               mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      case (size_q)
         2'b00:   kb_last = CNT_W'(4 * 32 - 1);
         2'b01:   kb_last = CNT_W'(6 * 32 - 1);
         default: kb_last = CNT_W'(KEY_MAX - 1);
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      msg_d      = msg_q;
      key_d      = key_q;
      shadow_d   = shadow_q;
      result_d   = result_q;
      mode_lat_d = mode_lat_q;
      size_d     = size_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WMSG;
               cnt_d      = '0;
               msg_d      = msg_in;
               key_d      = key_in;
               mode_lat_d = mode_in;
               size_d     = size_in;
            end
         end
         S_WMSG: begin
            if (cnt_q == CNT_W'(MSG_W)) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            state_d = S_WKEY;
            cnt_d   = '0;
         end
         S_WKEY: begin
            if (cnt_q == kb_last) begin
               state_d = S_RD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD: begin
            // the cnt=0 sample is the slave's flush bit and is dropped
            if (cnt_q != '0) shadow_d = {SOMI, shadow_q[MSG_W-1:1]};
            if (cnt_q == CNT_W'(MSG_W)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so the registered pins line
      // up with state_q/cnt_q; message and key shift out as they are sent.
      simo_d = 1'b0;
      if (state_d == S_WMSG && cnt_d != '0) begin
         simo_d = msg_q[0];
         msg_d  = msg_q >> 1;
      end else if (state_d == S_WKEY) begin
         simo_d = key_q[0];
         key_d  = key_q >> 1;
      end

      case (state_d)
         S_WKEY:  mode_d = mode_lat_q;
         S_RD:    mode_d = 1'b1;
         default: mode_d = 1'b0;
      endcase

      css_d  = (state_d == S_IDLE) || (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      if (state_d == S_DONE) result_d = shadow_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         msg_q      <= '0;
         key_q      <= '0;
         shadow_q   <= '0;
         result_q   <= '0;
         mode_lat_q <= 1'b0;
         size_q     <= 2'b00;
         simo_q     <= 1'b0;
         css_q      <= 1'b1;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         msg_q      <= msg_d;
         key_q      <= key_d;
         shadow_q   <= shadow_d;
         result_q   <= result_d;
         mode_lat_q <= mode_lat_d;
         size_q     <= size_d;
         simo_q     <= simo_d;
         css_q      <= css_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign SIMO   = simo_q;
   assign CSS    = css_q;
   assign mode   = mode_q;
   assign size   = size_q;
   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: a CSS-driven slave model serves SOMI and records
// SIMO; expectations come from the serial framing rules of the link.
module tb_aes_spi_master;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         mode_in;
   logic [1:0]   size_in;
   logic [127:0] msg_in;
   logic [255:0] key_in;
   logic         SIMO;
   logic         CSS;
   logic         mode;
   logic [1:0]   size;
   logic         SOMI;
   logic [127:0] result;
   logic         busy;
   logic         done;

   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;

   logic         cap_simo[$];
   logic         cap_mode[$];
   logic         exp_q[$];
   int unsigned  low_cnt, done_cyc, busy_low;
   logic [127:0] res_at_done;

   always #5 clk = ~clk;

   aes_spi_master #(.MSG_W(128), .KEY_MAX(256), .CNT_W(9)) dut (
      .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
      .size_in(size_in), .msg_in(msg_in), .key_in(key_in),
      .SIMO(SIMO), .CSS(CSS), .mode(mode), .size(size), .SOMI(SOMI),
      .result(result), .busy(busy), .done(done)
   );

   function automatic int unsigned ref_kb(input logic [1:0] sz);
      int unsigned nk;
      nk = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 6 : 8;
      return nk * 32;
   endfunction

   function automatic int unsigned ref_latency(input logic [1:0] sz);
      return 1 + 129 + 1 + ref_kb(sz) + 129 + 1;
   endfunction

   // Everything seen on SIMO while CSS is low: dummy, msg, gap, key, read zeros.
   function automatic void build_ref(input logic [127:0] m, input logic [255:0] k,
                                     input logic [1:0] sz);
      int unsigned kb;
      kb = ref_kb(sz);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int unsigned i = 0; i < 128; i++) exp_q.push_back(m[i]);
      exp_q.push_back(1'b0);
      for (int unsigned i = 0; i < kb; i++) exp_q.push_back(k[i]);
      for (int unsigned i = 0; i < 129; i++) exp_q.push_back(1'b0);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand128(), rand128()};
   endfunction

   // Drives one transaction; the slave counts CSS-low cycles to find its read slots.
   task automatic run_txn(input logic [127:0] m, input logic [255:0] k, input logic [1:0] sz,
                          input logic md, input logic [127:0] rd, input bit poke);
      int unsigned kb, cyc, j, rk;
      kb = ref_kb(sz);
      cap_simo.delete();
      cap_mode.delete();
      low_cnt = 0; done_cyc = 0; busy_low = 0; res_at_done = '0;
      msg_in = m; key_in = k; size_in = sz; mode_in = md; start = 1'b1;
      cyc = 1;
      while (done_cyc == 0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         SOMI = 1'($urandom);
         if (!CSS) begin
            j = low_cnt;
            cap_simo.push_back(SIMO);
            cap_mode.push_back(mode);
            if (j >= 130 + kb) begin
               rk = j - 130 - kb;
               if (rk >= 1 && rk <= 128) SOMI = rd[rk-1];
            end
            low_cnt++;
         end
         if (!busy) busy_low++;
         if (done) begin
            done_cyc    = cyc;
            res_at_done = result;
         end
         start = (poke && (cyc == 50 || done)) ? 1'b1 : 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; SOMI = 1'b0; mode_in = 1'b0;
      size_in = 2'b00; msg_in = '0; key_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (CSS !== 1'b1)     begin n_err++; $display("FAIL rst_css: got %b want 1", CSS); end
      n_cmp++; if (SIMO !== 1'b0)    begin n_err++; $display("FAIL rst_simo: got %b want 0", SIMO); end
      n_cmp++; if (mode !== 1'b0)    begin n_err++; $display("FAIL rst_mode: got %b want 0", mode); end
      n_cmp++; if (size !== 2'b00)   begin n_err++; $display("FAIL rst_size: got %b want 00", size); end
      n_cmp++; if (result !== '0)    begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
      reset = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || CSS !== 1'b1) begin
         n_err++; $display("FAIL rst_idle: busy=%b css=%b want busy=0 css=1", busy, CSS);
      end
   endtask

   task automatic test_write128();
      logic [127:0] m, rd;
      logic [255:0] k;
      int bad;
      m  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      k  = {128'h0, 128'h00010203_04050607_08090A0B_0C0D0E0F};
      rd = rand128();
      build_ref(m, k, 2'b00);
      run_txn(m, k, 2'b00, 1'b0, rd, 1'b0);
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < cap_simo.size(); i++)
         if (bad < 0 && cap_simo[i] !== exp_q[i]) bad = i;
      n_cmp++; if (cap_simo.size() != exp_q.size() || bad >= 0) begin
         n_err++; $display("FAIL w128_stream: len %0d first_bad %0d, want len %0d no bad", cap_simo.size(), bad, exp_q.size());
      end
      n_cmp++; if (low_cnt != 258 + 129) begin
         n_err++; $display("FAIL w128_css_low: got %0d cycles want %0d", low_cnt, 258 + 129);
      end
      bad = -1;
      for (int i = 0; i < cap_mode.size(); i++)
         if (bad < 0 && ((i < 129 && cap_mode[i] !== 1'b0) || (i >= 258 && cap_mode[i] !== 1'b1))) bad = i;
      n_cmp++; if (bad >= 0) begin
         n_err++; $display("FAIL w128_mode: bad at low-cycle %0d, want 0 in WMSG and 1 in RD", bad);
      end
      n_cmp++; if (done_cyc != ref_latency(2'b00)) begin
         n_err++; $display("FAIL w128_latency: got %0d want %0d", done_cyc, ref_latency(2'b00));
      end
      n_cmp++; if (busy_low != 0 || res_at_done !== rd) begin
         n_err++; $display("FAIL w128_busy_result: busy_low %0d result %h want 0 and %h", busy_low, res_at_done, rd);
      end
      @(negedge clk);
   endtask

   task automatic test_key_sizes();
      logic [127:0] m, rd;
      logic [255:0] k;
      logic [1:0]   sz;
      int bad;
      for (int s = 1; s <= 2; s++) begin
         sz = 2'(s);
         m = rand128(); k = rand256(); rd = rand128();
         build_ref(m, k, sz);
         run_txn(m, k, sz, 1'($urandom), rd, 1'b0);
         bad = -1;
         for (int i = 0; i < exp_q.size() && i < cap_simo.size(); i++)
            if (bad < 0 && cap_simo[i] !== exp_q[i]) bad = i;
         n_cmp++; if (cap_simo.size() != exp_q.size() || bad >= 0) begin
            n_err++; $display("FAIL ks%0d_stream: len %0d first_bad %0d, want len %0d", s, cap_simo.size(), bad, exp_q.size());
         end
         n_cmp++; if (done_cyc != ref_latency(sz)) begin
            n_err++; $display("FAIL ks%0d_latency: got %0d want %0d", s, done_cyc, ref_latency(sz));
         end
         n_cmp++; if (res_at_done !== rd) begin
            n_err++; $display("FAIL ks%0d_result: got %h want %h", s, res_at_done, rd);
         end
         n_cmp++; if (size !== sz) begin
            n_err++; $display("FAIL ks%0d_size_pin: got %b want %b", s, size, sz);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_readback();
      logic [127:0] rd;
      rd = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
      run_txn(rand128(), rand256(), 2'b00, 1'b1, rd, 1'b0);
      n_cmp++; if (res_at_done !== rd) begin
         n_err++; $display("FAIL rb_at_done: got %h want %h", res_at_done, rd);
      end
      repeat (5) @(negedge clk);
      n_cmp++; if (result !== rd) begin
         n_err++; $display("FAIL rb_hold: got %h want %h", result, rd);
      end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL rb_after: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_reset_mid();
      int unsigned seen;
      msg_in = rand128(); key_in = rand256(); size_in = 2'b00; mode_in = 1'b0;
      SOMI = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (150) @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || CSS !== 1'b0) begin
         n_err++; $display("FAIL rm_active: busy=%b css=%b want 1 0", busy, CSS);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (CSS !== 1'b1)  begin n_err++; $display("FAIL rm_css: got %b want 1", CSS); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b want 0", done); end
      n_cmp++; if (result !== '0 || SIMO !== 1'b0) begin
         n_err++; $display("FAIL rm_result: result %h simo %b want 0 0", result, SIMO);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || CSS !== 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin
         n_err++; $display("FAIL rm_stay_idle: %0d active cycles want 0", seen);
      end
   endtask

   task automatic test_handshake();
      logic [127:0] rd;
      int unsigned act;
      rd = rand128();
      run_txn(rand128(), rand256(), 2'b01, 1'b0, rd, 1'b1);
      n_cmp++; if (done_cyc != ref_latency(2'b01) || busy_low != 0) begin
         n_err++; $display("FAIL hs_latency: got %0d busy_low %0d want %0d 0", done_cyc, busy_low, ref_latency(2'b01));
      end
      n_cmp++; if (res_at_done !== rd) begin
         n_err++; $display("FAIL hs_result: got %h want %h", res_at_done, rd);
      end
      @(negedge clk);
      start = 1'b0;
      act = 0;
      repeat (4) begin
         if (busy !== 1'b0 || CSS !== 1'b1) act++;
         @(negedge clk);
      end
      n_cmp++; if (act != 0) begin
         n_err++; $display("FAIL hs_done_start_ignored: %0d active cycles want 0", act);
      end
      run_txn(rand128(), rand256(), 2'b00, 1'b0, rand128(), 1'b0);
      n_cmp++; if (done_cyc != ref_latency(2'b00)) begin
         n_err++; $display("FAIL hs_next_txn: got %0d want %0d", done_cyc, ref_latency(2'b00));
      end
      @(negedge clk);
   endtask

   task automatic test_size11();
      logic [127:0] m, rd;
      logic [255:0] k;
      logic         ref10[$];
      int unsigned  lat10;
      int bad;
      m = rand128(); k = rand256(); rd = rand128();
      run_txn(m, k, 2'b10, 1'b0, rd, 1'b0);
      ref10 = cap_simo;
      lat10 = done_cyc;
      @(negedge clk);
      build_ref(m, k, 2'b11);
      run_txn(m, k, 2'b11, 1'b0, rd, 1'b0);
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < cap_simo.size(); i++)
         if (bad < 0 && cap_simo[i] !== exp_q[i]) bad = i;
      n_cmp++; if (cap_simo.size() != exp_q.size() || bad >= 0) begin
         n_err++; $display("FAIL s11_stream: len %0d first_bad %0d, want len %0d", cap_simo.size(), bad, exp_q.size());
      end
      n_cmp++; if (done_cyc != 517 || lat10 != 517) begin
         n_err++; $display("FAIL s11_latency: s11 %0d s10 %0d want 517 517", done_cyc, lat10);
      end
      n_cmp++; if (ref10 != cap_simo || res_at_done !== rd) begin
         n_err++; $display("FAIL s11_same_as_s10: result %h want %h, streams must match", res_at_done, rd);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write128();
      test_key_sizes();
      test_readback();
      test_reset_mid();
      test_handshake();
      test_size11();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
- Initiator end of the AES serial link: drives a serial AES slave over SIMO/CSS/mode/size, and reads the 128-bit result back over SOMI.
- One transaction has a write phase (message, then key, LSB-first) followed by a read phase (128 result bits).
- Sits between the system controller and the serial AES slave; it is the only driver of CSS.

Parameters:
- MSG_W, 128, message/result width in bits.
- KEY_MAX, 256, widest key in bits; key_in is KEY_MAX wide.
- CNT_W, 9, bit-counter width; must hold 129 and KEY_MAX.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode_in  input  1  operation (0 encrypt, 1 decrypt); latched on start.
- size_in  input  2  key size (00=128, 01=192, 10/11=256); latched on start.
- msg_in  input  128  message; latched on start.
- key_in  input  256  key, LSB-aligned; latched on start.
- SIMO  output  1  serial data to the slave.
- CSS  output  1  chip select, active low.
- mode  output  1  mode to the slave.
- size  output  2  size to the slave.
- SOMI  input  1  serial data from the slave.
- result  output  128  received result; holds until the next transaction's DONE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, CSS=1, SIMO=0, mode=0, size=00, result=0, busy=0, done=0, counter=0.
- Reset asserted mid-transaction aborts immediately with the same values; no partial result is kept.
- Nk = 4/6/8 for latched size 00/01/(10 or 11). Key bit count KB = Nk*32.
- IDLE:
  - CSS=1. On start=1, latch inputs, go to WMSG with cnt=0.
  - start is ignored in every other state.
- WMSG (129 cycles, cnt 0..128):
  - CSS=0, mode=0 (write), size=latched.
  - cnt=0 drives SIMO=0 (dummy bit, flushed by the slave).
  - cnt=k (1..128) drives SIMO=msg[k-1].
  - After cnt=128, go to GAP.
- GAP (1 cycle): CSS=0, SIMO=0. Next state WKEY, cnt=0.
- WKEY (KB cycles):
  - SIMO=key[cnt], LSB-first.
  - After cnt=KB-1, go to RD with cnt=0.
  - Key bits at or above KB are never sent.
- RD (129 cycles):
  - CSS=0, mode=latched mode_in driven as 1 (readback); SIMO=0.
  - The SOMI value seen at the posedge ending RD cycle cnt=k (1..128) is shifted into result bit k-1 via a shadow register.
  - The cnt=0 sample is discarded.
  - After cnt=128, go to DONE.
- DONE (1 cycle): CSS=1, copy shadow to result, done=1, busy=1. Next state IDLE.
- Outputs SIMO, CSS, mode and size are registered; they change only on posedge.
- Total latency, start to done pulse: 1 + 129 + 1 + KB + 129 + 1.
  - 128-bit key: 389 cycles. 192-bit: 453. 256-bit: 517.
- Counter never wraps; compare against the terminal value, then clear.
- start asserted in the same cycle as DONE is ignored. A new start is accepted from the following IDLE cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-WKEY -> CSS=1, busy=0, done=0, result=0 on the next posedge; after release, stays IDLE with no start.
- 128-bit write: msg=0x00112233_44556677_8899AABB_CCDDEEFF, key=0x000102..0F, size=00 -> serial monitor sees dummy 0, 128 msg bits LSB-first, 1 gap, 128 key bits LSB-first; CSS low for exactly 258 write cycles.
- Key sizes: size=01 and size=10 -> WKEY lasts exactly 192 and 256 cycles; done at cycle 453 and 517 after start.
- Readback: slave model returns 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A LSB-first -> result equals that value at the done pulse and holds afterwards.
- Handshake: start pulsed during WMSG, and again on the DONE cycle -> both ignored; busy stays high until IDLE; second transaction starts only on the next start.
- size=11 -> treated as 256-bit key, identical to size=10.
